// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// resolves sequential / B / BR / HLT next-PC when decode accepts an instruction.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_accept,
    input  logic [2:0]  flags,
    input  logic [15:0] rs_data,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        hlt
);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] pc_r;
    logic [15:0] pc_next_s;
    logic [15:0] instr_r;
    logic [15:0] instr_next_s;
    logic        imem_req_r;
    logic        instr_valid_r;
    logic        hlt_r;

    logic [15:0] pc_plus2_s;
    logic [15:0] b_offset_s;
    logic [15:0] b_target_s;
    logic        cond_taken_s;

    // Flag-based branch condition; flag order is {Z,V,N}.
    function automatic logic branch_taken(input logic [2:0] cond, input logic [2:0] f);
        logic z;
        logic v;
        logic n;
        logic t;
        z = f[2];
        v = f[1];
        n = f[0];
        case (cond)
            3'b000:  t = ~z;
            3'b001:  t = z;
            3'b010:  t = ~z & ~n;
            3'b011:  t = n;
            3'b100:  t = z | ~n;
            3'b101:  t = z | n;
            3'b110:  t = v;
            3'b111:  t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // PC arithmetic; all sums wrap modulo 2^16.
    always_comb begin
        pc_plus2_s   = pc_r + 16'd2;
        b_offset_s   = {{6{instr_r[8]}}, instr_r[8:0], 1'b0};
        b_target_s   = pc_plus2_s + b_offset_s;
        cond_taken_s = branch_taken(instr_r[11:9], flags);
    end

    // Next-state, next-PC and instruction capture.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        instr_next_s = instr_r;
        case (state_r)
            S_RST: begin
                state_next_s = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_next_s = imem_data;
                    state_next_s = S_VALID;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_VALID: begin
                if (instr_accept) begin
                    case (instr_r[15:12])
                        OP_HLT: begin
                            state_next_s = S_HALT;
                        end
                        OP_B: begin
                            pc_next_s    = cond_taken_s ? b_target_s : pc_plus2_s;
                            state_next_s = S_FETCH;
                        end
                        OP_BR: begin
                            pc_next_s    = cond_taken_s ? rs_data : pc_plus2_s;
                            state_next_s = S_FETCH;
                        end
                        default: begin
                            pc_next_s    = pc_plus2_s;
                            state_next_s = S_FETCH;
                        end
                    endcase
                end else begin
                    state_next_s = S_VALID;
                end
            end
            S_HALT: begin
                state_next_s = S_HALT;
            end
            default: begin
                // An unreachable encoding recovers through the reset state.
                state_next_s = S_RST;
            end
        endcase
    end

    // State, PC, instruction and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= S_RST;
            pc_r          <= RESET_PC;
            instr_r       <= 16'h0000;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            hlt_r         <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            instr_r       <= instr_next_s;
            imem_req_r    <= (state_next_s == S_FETCH);
            instr_valid_r <= (state_next_s == S_VALID);
            hlt_r         <= (state_next_s == S_HALT);
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign pc          = pc_r;
    assign pc_plus2    = pc_plus2_s;
    assign hlt         = hlt_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: inputs driven and outputs sampled on the
// falling clock edge, expected values hand-computed.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_accept;
    logic [2:0]  flags;
    logic [15:0] rs_data;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        hlt;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_accept (instr_accept),
        .flags        (flags),
        .rs_data      (rs_data),
        .pc           (pc),
        .pc_plus2     (pc_plus2),
        .hlt          (hlt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full fetch with a same-cycle ack followed by a one-cycle accept.
    task automatic do_fetch(input logic [15:0] exp_addr, input logic [15:0] data,
                            input logic [2:0] f, input logic [15:0] rs);
        chk("fetch_req", {15'd0, imem_req}, 16'd1);
        chk("fetch_addr", imem_addr, exp_addr);
        chk("fetch_hlt", {15'd0, hlt}, 16'd0);
        imem_ack  = 1'b1;
        imem_data = data;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("valid_set", {15'd0, instr_valid}, 16'd1);
        chk("instr", instr, data);
        chk("pc_hold", pc, exp_addr);
        chk("pc_plus2", pc_plus2, exp_addr + 16'd2);
        chk("req_off", {15'd0, imem_req}, 16'd0);
        flags        = f;
        rs_data      = rs;
        instr_accept = 1'b1;
        @(negedge clk);
        instr_accept = 1'b0;
        chk("valid_drop", {15'd0, instr_valid}, 16'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        imem_data    = 16'h0000;
        instr_accept = 1'b0;
        flags        = 3'b000;
        rs_data      = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_hlt", {15'd0, hlt}, 16'd0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_instr", instr, 16'h0000);

        rst_n = 1'b1;
        @(negedge clk);
        // sequential fetches
        do_fetch(16'h0000, 16'h1000, 3'b000, 16'h0000);
        do_fetch(16'h0002, 16'h2000, 3'b000, 16'h0000);
        // BR UN to 0xFFFE, then sequential wrap to 0x0000
        do_fetch(16'h0004, 16'hDE10, 3'b000, 16'hFFFE);
        do_fetch(16'hFFFE, 16'h1000, 3'b000, 16'h0000);
        do_fetch(16'h0000, 16'hDE10, 3'b000, 16'h0010);
        // B EQ -4 at 0x0010, taken with Z=1
        do_fetch(16'h0010, 16'hC3FC, 3'b100, 16'h0000);
        do_fetch(16'h000A, 16'h1000, 3'b000, 16'h0000);
        do_fetch(16'h000C, 16'h1000, 3'b000, 16'h0000);
        do_fetch(16'h000E, 16'h1000, 3'b000, 16'h0000);
        // same branch, not taken with Z=0
        do_fetch(16'h0010, 16'hC3FC, 3'b000, 16'h0000);
        // B LT +4 with N=1: 0x14 + 8
        do_fetch(16'h0012, 16'hC604, 3'b001, 16'h0000);
        do_fetch(16'h001C, 16'hDE00, 3'b000, 16'h0020);
        // BR UN at 0x0020 to 0x1234, then back
        do_fetch(16'h0020, 16'hDE00, 3'b000, 16'h1234);
        do_fetch(16'h1234, 16'hDE00, 3'b000, 16'h0020);
        // BR OV with V=0 falls through
        do_fetch(16'h0020, 16'hDC00, 3'b000, 16'h5555);

        // ack delayed 3 cycles with accept held high
        instr_accept = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", {15'd0, imem_req}, 16'd1);
            chk("wait_addr", imem_addr, 16'h0022);
            chk("wait_valid", {15'd0, instr_valid}, 16'd0);
            @(negedge clk);
        end
        chk("wait_pc", pc, 16'h0022);
        imem_ack  = 1'b1;
        imem_data = 16'h3000;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("late_valid", {15'd0, instr_valid}, 16'd1);
        chk("late_instr", instr, 16'h3000);
        chk("late_pc", pc, 16'h0022);
        @(negedge clk);
        instr_accept = 1'b0;
        chk("late_valid_drop", {15'd0, instr_valid}, 16'd0);
        chk("late_pc_adv", pc, 16'h0024);
        chk("late_req", {15'd0, imem_req}, 16'd1);

        // reset while a fetch is pending, then a stale ack
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_pc", pc, 16'h0000);
        chk("midrst_req", {15'd0, imem_req}, 16'd0);
        chk("midrst_valid", {15'd0, instr_valid}, 16'd0);
        rst_n     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 16'hBEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("stale_instr", instr, 16'h0000);
        chk("stale_valid", {15'd0, instr_valid}, 16'd0);
        do_fetch(16'h0000, 16'h1000, 3'b000, 16'h0000);
        do_fetch(16'h0002, 16'h1000, 3'b000, 16'h0000);
        do_fetch(16'h0004, 16'h1000, 3'b000, 16'h0000);
        do_fetch(16'h0006, 16'h1000, 3'b000, 16'h0000);
        // HLT at 0x0008
        do_fetch(16'h0008, 16'hF000, 3'b000, 16'h0000);
        chk("halt_hlt", {15'd0, hlt}, 16'd1);
        chk("halt_pc", pc, 16'h0008);
        chk("halt_req", {15'd0, imem_req}, 16'd0);
        imem_ack  = 1'b1;
        imem_data = 16'h1111;
        @(negedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("halt_instr", instr, 16'hF000);
        chk("halt_hlt_hold", {15'd0, hlt}, 16'd1);
        chk("halt_valid", {15'd0, instr_valid}, 16'd0);
        chk("halt_pc_hold", pc, 16'h0008);
        chk("halt_req_hold", {15'd0, imem_req}, 16'd0);
        // only reset leaves HALT
        rst_n = 1'b0;
        @(negedge clk);
        chk("exit_hlt", {15'd0, hlt}, 16'd0);
        chk("exit_pc", pc, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("exit_req", {15'd0, imem_req}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage for the 16-bit CPU: owns the PC register and drives the instruction memory through a req/ack handshake.
- Presents each fetched instruction to decode/execute with a valid/accept handshake.
- On accept, resolves the next PC itself: sequential, B (conditional, flag-based), BR (register target) or HLT.
- Sits directly upstream of the register file / ALU / data-memory datapath.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset; sampled on rising clk
imem_req  output  1  fetch request to instruction memory
imem_addr  output  16  fetch byte address (equals pc)
imem_ack  input  1  memory returns imem_data this cycle
imem_data  input  16  instruction word from memory
instr  output  16  registered fetched instruction
instr_valid  output  1  instr holds an unconsumed instruction
instr_accept  input  1  consumer takes instr; flags and rs_data valid this cycle
flags  input  3  {Z,V,N} from the ALU flag register
rs_data  input  16  register-file read of instr[7:4], used as the BR target
pc  output  16  address of the current or pending instruction
pc_plus2  output  16  pc+2, combinational, for PCS write-back
hlt  output  1  asserted once HLT is retired

Behaviour:
- Single clock. Reset is synchronous and active-low, port names clk and rst_n. All state updates on rising clk.

Reset values:
- state=S_RST, pc=RESET_PC, instr=16'h0000.
- instr_valid=0, imem_req=0, hlt=0.
- Reset takes priority over every other input in every state, including mid-fetch and HALTED.

States:
- S_RST: imem_req=0. Next cycle -> S_FETCH.
- S_FETCH: imem_req=1, imem_addr=pc; both stay stable until ack. On a clk edge with imem_ack=1: instr<=imem_data, go S_VALID. An ack arriving in the same cycle as req is legal, giving a 1-cycle fetch.
- S_VALID: instr_valid=1, imem_req=0. Without accept, hold instr and pc indefinitely. With accept, resolve the next PC (below).
- S_HALT: hlt=1, instr_valid=0, imem_req=0. pc holds the HLT address. Exits only by reset.

Stale acks:
- imem_ack while imem_req=0 (S_RST, S_VALID, S_HALT) is ignored. This covers acks still in flight after a mid-fetch reset.

Next-PC resolution on accept in S_VALID (opcode = instr[15:12]):
- 4'b1111 HLT: go S_HALT; pc unchanged.
- 4'b1100 B: cond=instr[11:9], imm9=instr[8:0]. If taken, pc <= pc+2 + (signext(imm9)<<1); otherwise pc <= pc+2. Go S_FETCH.
- 4'b1101 BR: cond=instr[11:9]. If taken, pc <= rs_data (bit 0 not masked); otherwise pc <= pc+2. Go S_FETCH.
- Any other opcode: pc <= pc+2, go S_FETCH.

Branch conditions (Z=flags[2], V=flags[1], N=flags[0]):
- 000 NE: Z=0
- 001 EQ: Z=1
- 010 GT: Z=0 and N=0
- 011 LT: N=1
- 100 GE: Z=1 or (Z=0 and N=0)
- 101 LE: Z=1 or N=1
- 110 OV: V=1
- 111 UN: always taken

Arithmetic and timing:
- All PC arithmetic is modulo 2^16; 16'hFFFE+2 wraps to 16'h0000. Branch targets wrap the same way.
- A retired instruction takes at least 2 cycles: fetch plus accept. instr_valid drops the cycle after accept.
- pc_plus2 = pc+2, always combinational.

Test Plan:
- Reset then sequential fetch, memory acks same cycle, consumer accepts every valid: imem_addr sequence 0000, 0002, 0004; instr_valid pulses every 2nd cycle; hlt=0.
- B EQ with imm9=9'h1FC (-4) at pc=0x0010: with flags Z=1, next imem_addr=0x000A; with Z=0, next imem_addr=0x0012.
- BR UN at pc=0x0020 with rs_data=0x1234: next imem_addr=0x1234. BR OV with V=0: next imem_addr=0x0022.
- HLT at 0x0008: accepted -> hlt=1 on the next cycle, pc stays 0x0008, imem_req stays 0; a later imem_ack is ignored.
- Memory delays ack by 3 cycles while instr_accept is held 1: imem_req and imem_addr stay stable; instr_valid=0 until the edge after ack; no PC advance.
- rst_n=0 while imem_req=1 and ack pending: next cycle pc=RESET_PC and req=0; a stale ack 1 cycle later is ignored; the fetch of 0x0000 follows.
